// File: rtl/ptw_pkg.sv
// Sv39 page-table walker shared definitions: geometry, walk states, PTE
// layout and the L1D command codes the wire path issues for each request state.
package ptw_pkg;

    localparam int unsigned PTE_ADDR_W = 50;
    localparam int unsigned PPN_W      = 38;
    localparam int unsigned VPN_W      = 27;
    localparam int unsigned LEVELS     = 3;
    localparam int unsigned IDX_W      = 9;
    localparam int unsigned CNT_W      = 2;
    localparam int unsigned PERM_W     = 8;
    localparam int unsigned STATE_W    = 3;
    localparam int unsigned SUPER1G_W  = 18;   // ppn bits that must be zero for a 1 GiB leaf
    localparam int unsigned SUPER2M_W  = 9;    // ppn bits that must be zero for a 2 MiB leaf
    localparam int unsigned MEM_CMD_W  = 5;

    // L1D commands: S_REQ issues a load, S_SET_DIRTY issues an AMO-OR.
    localparam logic [MEM_CMD_W-1:0] M_XRD   = 5'b00000;
    localparam logic [MEM_CMD_W-1:0] M_XA_OR = 5'b01010;

    // Encoding is fixed: the wire path decodes S_REQ and S_SET_DIRTY directly.
    typedef enum logic [STATE_W-1:0] {
        S_READY       = 3'd0,
        S_REQ         = 3'd1,
        S_WAIT1       = 3'd2,
        S_WAIT2       = 3'd3,
        S_SET_DIRTY   = 3'd4,
        S_WAIT1_DIRTY = 3'd5,
        S_WAIT2_DIRTY = 3'd6,
        S_DONE        = 3'd7
    } ptw_state_e;

    // Decoded PTE; the low byte is the perm field {d, a, g, u, x, w, r, v}.
    typedef struct packed {
        logic [PPN_W-1:0] ppn;
        logic             d;
        logic             a;
        logic             g;
        logic             u;
        logic             x;
        logic             w;
        logic             r;
        logic             v;
    } pte_t;

    // VPN slice indexing the table at walk depth count (0 = root).
    function automatic logic [IDX_W-1:0] vpn_idx(input logic [VPN_W-1:0] vpn,
                                                 input logic [CNT_W-1:0] count);
        case (count)
            2'd0:    return vpn[26:18];
            2'd1:    return vpn[17:9];
            default: return vpn[8:0];
        endcase
    endfunction

endpackage

// File: rtl/ptw_pte_check.sv
// Combinational PTE classifier for one walk step.
// Inputs : low ppn bits, v/r/w/x/a/d, walk depth, store flag.
// Outputs: is_next_o (descend a level), fault_o (page fault),
//          need_ad_o (valid leaf whose A/D bits must be set first).
module ptw_pte_check
    import ptw_pkg::*;
(
    input  logic [SUPER1G_W-1:0] ppn_lo_i,
    input  logic                 v_i,
    input  logic                 r_i,
    input  logic                 w_i,
    input  logic                 x_i,
    input  logic                 a_i,
    input  logic                 d_i,
    input  logic [CNT_W-1:0]     count_i,
    input  logic                 store_i,
    output logic                 is_next_o,
    output logic                 fault_o,
    output logic                 need_ad_o
);

    logic leaf;
    logic misaligned;

    assign leaf      = r_i | w_i | x_i;
    assign is_next_o = v_i & ~leaf & (count_i < CNT_W'(LEVELS - 1));

    // Superpage leaves must point at a naturally aligned region.
    assign misaligned = ((count_i == CNT_W'(0)) && (ppn_lo_i != '0)) ||
                        ((count_i == CNT_W'(1)) && (ppn_lo_i[SUPER2M_W-1:0] != '0));

    // A non-leaf reaching here is at the last level, which is itself a fault.
    assign fault_o   = ~is_next_o & (~v_i | (w_i & ~r_i) | ~leaf | misaligned);
    assign need_ad_o = ~is_next_o & ~fault_o & (~a_i | (store_i & ~d_i));

endmodule

// File: rtl/ptw_walk_ctrl.sv
// Sv39 page-table walk controller. Takes one TLB refill request, walks up to
// three levels through mem_wire_path / L1D, sets A/D with an AMO-OR when
// needed, and returns the leaf PTE or a page fault as a one-cycle pulse.
// Ports: io_req_*  TLB request handshake; io_resp_* result pulse;
//        io_dpath_ptbr_ppn root table; io_mem_* L1D handshake;
//        pte_* decoded PTE from the wire path; state/pte_addr/r_req_store/
//        s1_kill drive the wire path.
module ptw_walk_ctrl
    import ptw_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_req_valid,
    output logic                  io_req_ready,
    input  logic [VPN_W-1:0]      io_req_bits_addr,
    input  logic                  io_req_bits_store,
    output logic                  io_resp_valid,
    output logic                  io_resp_bits_error,
    output logic [CNT_W-1:0]      io_resp_bits_level,
    output logic [PPN_W-1:0]      io_resp_bits_pte_ppn,
    output logic [PERM_W-1:0]     io_resp_bits_pte_perm,
    input  logic [PPN_W-1:0]      io_dpath_ptbr_ppn,
    input  logic                  io_mem_req_ready,
    input  logic                  io_mem_resp_valid,
    input  logic                  io_mem_s2_nack,
    input  logic [PPN_W-1:0]      pte_ppn,
    input  logic                  pte_d,
    input  logic                  pte_a,
    input  logic                  pte_u,
    input  logic                  pte_x,
    input  logic                  pte_w,
    input  logic                  pte_r,
    input  logic                  pte_v,
    input  logic                  pte_g,
    output logic [STATE_W-1:0]    state,
    output logic [PTE_ADDR_W-1:0] pte_addr,
    output logic                  r_req_store,
    output logic                  s1_kill
);

    ptw_state_e       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PPN_W-1:0] r_ppn_q, r_ppn_d;
    logic [VPN_W-1:0] vpn_q, vpn_d;
    logic             store_q, store_d;
    logic             err_q, err_d;
    pte_t             lat_q, lat_d;

    pte_t pte_in;
    logic is_next;
    logic fault;
    logic need_ad;

    assign pte_in = {pte_ppn, pte_d, pte_a, pte_g, pte_u, pte_x, pte_w, pte_r, pte_v};

    ptw_pte_check u_pte_check (
        .ppn_lo_i  (pte_ppn[SUPER1G_W-1:0]),
        .v_i       (pte_v),
        .r_i       (pte_r),
        .w_i       (pte_w),
        .x_i       (pte_x),
        .a_i       (pte_a),
        .d_i       (pte_d),
        .count_i   (count_q),
        .store_i   (store_q),
        .is_next_o (is_next),
        .fault_o   (fault),
        .need_ad_o (need_ad)
    );

    // Walk state and captured request/PTE registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_READY;
            count_q <= '0;
            r_ppn_q <= '0;
            vpn_q   <= '0;
            store_q <= 1'b0;
            err_q   <= 1'b0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            r_ppn_q <= r_ppn_d;
            vpn_q   <= vpn_d;
            store_q <= store_d;
            err_q   <= err_d;
            lat_q   <= lat_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        r_ppn_d = r_ppn_q;
        vpn_d   = vpn_q;
        store_d = store_q;
        err_d   = err_q;
        lat_d   = lat_q;

        case (state_q)
            S_READY: begin
                if (io_req_valid) begin
                    vpn_d   = io_req_bits_addr;
                    store_d = io_req_bits_store;
                    r_ppn_d = io_dpath_ptbr_ppn;
                    count_d = '0;
                    err_d   = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (io_mem_req_ready) state_d = S_WAIT1;
            end
            S_WAIT1: state_d = S_WAIT2;
            S_WAIT2: begin
                // nack takes priority over a coincident resp: retry unchanged
                if (io_mem_s2_nack) begin
                    state_d = S_REQ;
                end else if (io_mem_resp_valid) begin
                    lat_d = pte_in;
                    err_d = fault;
                    if (is_next) begin
                        r_ppn_d = pte_ppn;
                        count_d = count_q + CNT_W'(1);
                        state_d = S_REQ;
                    end else if (need_ad) begin
                        state_d = S_SET_DIRTY;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_SET_DIRTY: begin
                if (io_mem_req_ready) state_d = S_WAIT1_DIRTY;
            end
            S_WAIT1_DIRTY: state_d = S_WAIT2_DIRTY;
            S_WAIT2_DIRTY: begin
                // after the AMO completes, re-read the same PTE to pick up A/D
                if (io_mem_s2_nack)         state_d = S_SET_DIRTY;
                else if (io_mem_resp_valid) state_d = S_REQ;
            end
            S_DONE:  state_d = S_READY;
            default: state_d = S_READY;
        endcase
    end

    assign io_req_ready          = (state_q == S_READY);
    assign io_resp_valid         = (state_q == S_DONE);
    assign io_resp_bits_error    = err_q;
    assign io_resp_bits_level    = count_q;
    assign io_resp_bits_pte_ppn  = lat_q.ppn;
    assign io_resp_bits_pte_perm = lat_q[PERM_W-1:0];

    assign state       = state_q;
    assign pte_addr    = {r_ppn_q, vpn_idx(vpn_q, count_q), 3'b000};
    assign r_req_store = store_q;
    assign s1_kill     = 1'b0;

endmodule

// File: tb/tb_ptw_walk_ctrl.sv
// Bench for ptw_walk_ctrl: plays the wire path + L1D from a sparse PTE memory
// and compares each walk with a level-by-level reference walk of that memory.
module tb_ptw_walk_ctrl;
    import ptw_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        io_req_valid, io_req_ready;
    logic [26:0] io_req_bits_addr;
    logic        io_req_bits_store;
    logic        io_resp_valid, io_resp_bits_error;
    logic [1:0]  io_resp_bits_level;
    logic [37:0] io_resp_bits_pte_ppn;
    logic [7:0]  io_resp_bits_pte_perm;
    logic [37:0] io_dpath_ptbr_ppn;
    logic        io_mem_req_ready, io_mem_resp_valid, io_mem_s2_nack;
    logic [37:0] pte_ppn;
    logic        pte_d, pte_a, pte_u, pte_x, pte_w, pte_r, pte_v, pte_g;
    logic [2:0]  state;
    logic [49:0] pte_addr;
    logic        r_req_store, s1_kill;

    always #5 clk = ~clk;

    ptw_walk_ctrl dut (
        .clk(clk), .reset(reset),
        .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
        .io_req_bits_addr(io_req_bits_addr), .io_req_bits_store(io_req_bits_store),
        .io_resp_valid(io_resp_valid), .io_resp_bits_error(io_resp_bits_error),
        .io_resp_bits_level(io_resp_bits_level), .io_resp_bits_pte_ppn(io_resp_bits_pte_ppn),
        .io_resp_bits_pte_perm(io_resp_bits_pte_perm), .io_dpath_ptbr_ppn(io_dpath_ptbr_ppn),
        .io_mem_req_ready(io_mem_req_ready), .io_mem_resp_valid(io_mem_resp_valid),
        .io_mem_s2_nack(io_mem_s2_nack),
        .pte_ppn(pte_ppn), .pte_d(pte_d), .pte_a(pte_a), .pte_u(pte_u), .pte_x(pte_x),
        .pte_w(pte_w), .pte_r(pte_r), .pte_v(pte_v), .pte_g(pte_g),
        .state(state), .pte_addr(pte_addr), .r_req_store(r_req_store), .s1_kill(s1_kill)
    );

    int checks = 0;
    int errors = 0;

    pte_t        mem  [logic [49:0]];   // memory seen by the DUT
    pte_t        mmem [logic [49:0]];   // reference model's copy
    logic [49:0] exp_addrs [$];
    logic [49:0] got_addrs [$];

    logic        last_err;
    logic [1:0]  last_lvl;
    logic [37:0] last_ppn;
    logic [7:0]  last_perm;
    int          last_amo, last_retries;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic pte_t mk(input logic [37:0] ppn, input logic [7:0] perm);
        pte_t p;
        p = {ppn, perm};
        return p;
    endfunction

    function automatic logic [49:0] paddr(input logic [37:0] ppn, input logic [26:0] vpn, input int lvl);
        logic [26:0] idx;
        idx = (vpn >> (9 * (2 - lvl))) & 27'h1FF;
        return 50'(ppn) * 50'd4096 + 50'(idx) * 50'd8;
    endfunction

    // Reference walk over mmem, including the A/D update and re-read.
    task automatic model(input logic [26:0] vpn, input logic st, input logic [37:0] ptbr,
                         output logic e_err, output logic [1:0] e_lvl, output pte_t e_pte,
                         output int e_amo);
        logic [37:0] ppn;
        int          lvl;
        pte_t        p;
        logic [49:0] a;
        logic        leafy, bad;
        ppn = ptbr; lvl = 0; e_amo = 0; e_err = 1'b1; e_lvl = 2'd0; e_pte = '0;
        exp_addrs.delete();
        for (int it = 0; it < 12; it++) begin
            a = paddr(ppn, vpn, lvl);
            exp_addrs.push_back(a);
            p = mmem.exists(a) ? mmem[a] : '0;
            leafy = p.r | p.w | p.x;
            if (p.v && !leafy && lvl < 2) begin
                ppn = p.ppn;
                lvl++;
                continue;
            end
            bad = !p.v || (p.w && !p.r) || !leafy ||
                  (lvl == 0 && (p.ppn % 38'd262144) != 38'd0) ||
                  (lvl == 1 && (p.ppn % 38'd512) != 38'd0);
            if (!bad && (!p.a || (st && !p.d))) begin
                p.a = 1'b1;
                if (st) p.d = 1'b1;
                mmem[a] = p;
                e_amo++;
                continue;
            end
            e_err = bad; e_lvl = 2'(lvl); e_pte = p;
            break;
        end
    endtask

    // Issue one request, act as wire path/L1D until the response, check it.
    task automatic run_walk(input logic [26:0] vpn, input logic st, input logic [37:0] ptbr,
                            input bit rnd_rdy, input int nack_pct, input int nack_read,
                            input int exp_lat, input bit rst_w2d);
        logic        e_err;
        logic [1:0]  e_lvl;
        pte_t        e_pte, p;
        int          e_amo;
        int          cyc, pulses, amo, ready_bad, done_cyc, post, retries;
        logic [49:0] cur, retry_a;
        bit          retry_pend, nacked_once, nk;
        cyc = 0; pulses = 0; amo = 0; ready_bad = 0; done_cyc = 0; post = 0; retries = 0;
        cur = '0; retry_a = '0; retry_pend = 0; nacked_once = 0;
        mmem = mem;
        model(vpn, st, ptbr, e_err, e_lvl, e_pte, e_amo);
        got_addrs.delete();

        @(negedge clk);
        chk("req_ready_idle", 64'(io_req_ready), 64'(1));
        io_req_valid = 1'b1; io_req_bits_addr = vpn; io_req_bits_store = st; io_dpath_ptbr_ppn = ptbr;
        @(posedge clk); #1;
        // request fields are don't-care after fire
        io_req_valid = 1'b0;
        io_req_bits_addr = 27'($urandom); io_req_bits_store = 1'($urandom);
        io_dpath_ptbr_ppn = 38'({$urandom, $urandom});

        while (cyc < 600 && post < 3) begin
            cyc++;
            if (cyc == 1) chk("r_req_store", 64'(r_req_store), 64'(st));
            if (pulses == 0 && io_req_ready) ready_bad++;
            if (io_resp_valid) begin
                pulses++;
                if (pulses == 1) begin
                    done_cyc = cyc;
                    last_err = io_resp_bits_error; last_lvl = io_resp_bits_level;
                    last_ppn = io_resp_bits_pte_ppn; last_perm = io_resp_bits_pte_perm;
                end
            end else if (pulses > 0) begin
                post++;
            end

            io_mem_req_ready  = rnd_rdy ? 1'($urandom) : 1'b1;
            io_mem_resp_valid = 1'b0;
            io_mem_s2_nack    = 1'b0;
            p = 50'({$urandom, $urandom});
            if (state == 3'd6 && rst_w2d) begin
                reset = 1'b1;
                @(posedge clk); #1;
                chk("rst_state", 64'(state), 64'(0));
                chk("rst_req_ready", 64'(io_req_ready), 64'(1));
                chk("rst_resp_valid", 64'(io_resp_valid), 64'(0));
                reset = 1'b0;
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    if (io_resp_valid) pulses++;
                    if (state != 3'd0) amo++;
                end
                chk("rst_no_resp", 64'(pulses), 64'(0));
                chk("rst_stays_idle", 64'(amo), 64'(0));
                return;
            end
            case (state)
                3'd1: if (io_mem_req_ready) begin
                    if (retry_pend) begin
                        chk("retry_addr", 64'(pte_addr), 64'(retry_a));
                        retry_pend = 0;
                    end
                    cur = pte_addr;
                end
                3'd4: if (io_mem_req_ready) begin
                    chk("amo_s1_data", 64'({r_req_store, 1'b1, 6'b0}), 64'({st, 1'b1, 6'b0}));
                    cur = pte_addr;
                end
                3'd3, 3'd6: begin
                    p = mem.exists(cur) ? mem[cur] : '0;
                    nk = ($urandom_range(99) < nack_pct);
                    if (state == 3'd3 && !nacked_once && got_addrs.size() == nack_read) begin
                        nk = 1;
                        nacked_once = 1;
                    end
                    io_mem_s2_nack    = nk;
                    io_mem_resp_valid = !nk || 1'($urandom);
                    if (state == 3'd3) begin
                        if (nk) begin
                            retry_pend = 1; retry_a = cur; retries++;
                        end else begin
                            got_addrs.push_back(cur);
                        end
                    end else if (!nk) begin
                        mem[cur].ppn = p.ppn;
                        mem[cur] = p;
                        mem[cur].a = 1'b1;
                        mem[cur].d = p.d | st;
                        amo++;
                    end
                end
                default: ;
            endcase
            pte_ppn = p.ppn; pte_d = p.d; pte_a = p.a; pte_g = p.g; pte_u = p.u;
            pte_x = p.x; pte_w = p.w; pte_r = p.r; pte_v = p.v;
            @(posedge clk); #1;
        end

        last_amo = amo; last_retries = retries;
        chk("resp_pulses", 64'(pulses), 64'(1));
        chk("ready_low_in_walk", 64'(ready_bad), 64'(0));
        chk("resp_error", 64'(last_err), 64'(e_err));
        chk("resp_level", 64'(last_lvl), 64'(e_lvl));
        chk("resp_ppn", 64'(last_ppn), 64'(e_pte.ppn));
        chk("resp_perm", 64'(last_perm), 64'(e_pte[7:0]));
        chk("amo_count", 64'(amo), 64'(e_amo));
        chk("read_count", 64'(got_addrs.size()), 64'(exp_addrs.size()));
        for (int i = 0; i < exp_addrs.size() && i < got_addrs.size(); i++)
            chk($sformatf("pte_addr[%0d]", i), 64'(got_addrs[i]), 64'(exp_addrs[i]));
        if (exp_lat >= 0) chk("latency", 64'(done_cyc), 64'(exp_lat));
        chk("back_to_ready", 64'(state), 64'(0));
    endtask

    initial begin
        logic [26:0] vpn;
        logic [37:0] ptbr, ppn;
        logic        st;
        pte_t        p;
        int          sh;

        reset = 1'b1; io_req_valid = 1'b0; io_req_bits_addr = '0; io_req_bits_store = 1'b0;
        io_dpath_ptbr_ppn = '0; io_mem_req_ready = 1'b0; io_mem_resp_valid = 1'b0;
        io_mem_s2_nack = 1'b0; pte_ppn = '0; pte_d = 0; pte_a = 0; pte_u = 0; pte_x = 0;
        pte_w = 0; pte_r = 0; pte_v = 0; pte_g = 0;
        last_err = 0; last_lvl = 0; last_ppn = 0; last_perm = 0; last_amo = 0; last_retries = 0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("reset_state", 64'(state), 64'(0));
        chk("reset_req_ready", 64'(io_req_ready), 64'(1));
        chk("reset_resp_valid", 64'(io_resp_valid), 64'(0));
        chk("reset_pte_addr", 64'(pte_addr), 64'(0));
        chk("reset_r_req_store", 64'(r_req_store), 64'(0));
        chk("s1_kill_low", 64'(s1_kill), 64'(0));

        // Three-level walk to a 4 KiB leaf with A=D=1.
        vpn = {9'd1, 9'd2, 9'd3}; ptbr = 38'h80000;
        mem.delete();
        mem[paddr(ptbr, vpn, 0)]       = mk(38'h100, 8'h01);
        mem[paddr(38'h100, vpn, 1)]    = mk(38'h200, 8'h01);
        mem[paddr(38'h200, vpn, 2)]    = mk(38'hABCDE, 8'hC3);
        run_walk(vpn, 1'b0, ptbr, 0, 0, -1, 10, 0);
        if (got_addrs.size() > 0) chk("l2_addr_literal", 64'(got_addrs[0]), 64'h80000008);
        chk("walk3_err", 64'(last_err), 64'(0));
        chk("walk3_level", 64'(last_lvl), 64'(2));
        chk("walk3_ppn", 64'(last_ppn), 64'h0ABCDE);

        // Misaligned 1 GiB leaf at level 0, A clear: fault with no AMO.
        mem.delete();
        mem[paddr(ptbr, vpn, 0)] = mk(38'h12345, 8'h03);
        run_walk(vpn, 1'b0, ptbr, 0, 0, -1, 4, 0);
        chk("misalign_err", 64'(last_err), 64'(1));
        chk("misalign_level", 64'(last_lvl), 64'(0));
        chk("misalign_no_amo", 64'(last_amo), 64'(0));

        // Store to a leaf with A=1, D=0: AMO, re-read, clean result.
        mem.delete();
        mem[paddr(ptbr, vpn, 0)]    = mk(38'h100, 8'h01);
        mem[paddr(38'h100, vpn, 1)] = mk(38'h200, 8'h01);
        mem[paddr(38'h200, vpn, 2)] = mk(38'h777, 8'h47);
        run_walk(vpn, 1'b1, ptbr, 0, 0, -1, 16, 0);
        chk("dirty_err", 64'(last_err), 64'(0));
        chk("dirty_amo", 64'(last_amo), 64'(1));
        chk("dirty_d_set", 64'(last_perm[7]), 64'(1));

        // nack on the level-1 read: identical address re-issued.
        mem[paddr(38'h200, vpn, 2)] = mk(38'h777, 8'hC7);
        run_walk(vpn, 1'b0, ptbr, 0, 0, 1, 13, 0);
        chk("nack_retry_seen", 64'(last_retries), 64'(1));

        // Invalid PTE at level 1.
        mem.delete();
        mem[paddr(ptbr, vpn, 0)]    = mk(38'h100, 8'h01);
        mem[paddr(38'h100, vpn, 1)] = mk(38'h55, 8'hC2);
        run_walk(vpn, 1'b0, ptbr, 0, 0, -1, 7, 0);
        chk("invalid_err", 64'(last_err), 64'(1));
        chk("invalid_level", 64'(last_lvl), 64'(1));

        // Reset while waiting on the A/D AMO.
        mem.delete();
        mem[paddr(ptbr, vpn, 0)]    = mk(38'h100, 8'h01);
        mem[paddr(38'h100, vpn, 1)] = mk(38'h200, 8'h01);
        mem[paddr(38'h200, vpn, 2)] = mk(38'h777, 8'h47);
        run_walk(vpn, 1'b1, ptbr, 0, 0, -1, -1, 1);

        // Randomised tables with random ready stalls and nacks.
        for (int t = 0; t < 40; t++) begin
            vpn = 27'($urandom); st = 1'($urandom); ptbr = 38'({$urandom, $urandom});
            mem.delete();
            ppn = ptbr;
            for (int l = 0; l < 3; l++) begin
                p = '0;
                case ($urandom_range(3))
                    0: begin
                        p = 46'({$urandom, $urandom});
                        p.v = 1'b1; p.r = 1'b0; p.w = 1'b0; p.x = 1'b0;
                    end
                    1: begin
                        sh = (l == 0) ? 18 : ((l == 1) ? 9 : 0);
                        p.ppn = (38'({$urandom, $urandom}) >> sh) << sh;
                        p.v = 1'b1; p.r = 1'b1; p.w = 1'($urandom); p.x = 1'($urandom);
                        p.a = 1'($urandom); p.d = 1'($urandom); p.g = 1'($urandom); p.u = 1'($urandom);
                    end
                    default: p = 46'({$urandom, $urandom});
                endcase
                mem[paddr(ppn, vpn, l)] = p;
                if (p.v && !p.r && !p.w && !p.x) ppn = p.ppn;
                else break;
            end
            run_walk(vpn, st, ptbr, 1, 15, -1, -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
